// File: rtl/mw_skid_pipe_pkg.sv
// Shared types and defaults for the memory-writeback skid pipe.
//   mw_bundle_t : payload at the default widths (regw, regmem, index, ALU result, read data)
//   mw_state_t  : occupancy of the two-slot pipe
//   bundle_width: bit width of a payload for given datapath/index widths
package mw_pkg;

  localparam int unsigned DefN  = 32;
  localparam int unsigned DefM  = 4;
  localparam int unsigned DefCw = 16;

  typedef struct packed {
    logic              regw;
    logic              regmem;
    logic [DefM-1:0]   reg_scr;
    logic [DefN-1:0]   alu_rslt;
    logic [DefN-1:0]   read_data;
  } mw_bundle_t;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StFull
  } mw_state_t;

  function automatic int unsigned bundle_width(int unsigned n, int unsigned m);
    return 2 + m + 2 * n;
  endfunction

endpackage

// File: rtl/mw_skid_pipe_if.sv
// Handshake + payload bundle between MEM stage, the skid pipe and the writeback stage.
//   *_M fields, in_valid, in_ready : MEM-side channel
//   *_W fields, out_valid, out_ready: writeback-side channel
// Modports: master = surrounding pipeline (drives MEM side, consumes WB side),
//           slave  = the skid pipe itself.
interface mw_skid_pipe_if #(
  parameter int unsigned N = mw_pkg::DefN,
  parameter int unsigned M = mw_pkg::DefM
);

  logic         in_valid;
  logic         in_ready;
  logic         regw_M;
  logic         regmem_M;
  logic [M-1:0] regScr_M;
  logic [N-1:0] ALUrslt_M;
  logic [N-1:0] readdata_M;

  logic         out_valid;
  logic         out_ready;
  logic         regw_W;
  logic         regmem_W;
  logic [M-1:0] regScr_W;
  logic [N-1:0] ALUrslt_W;
  logic [N-1:0] readdata_W;

  modport master (
    output in_valid, regw_M, regmem_M, regScr_M, ALUrslt_M, readdata_M, out_ready,
    input  in_ready, out_valid, regw_W, regmem_W, regScr_W, ALUrslt_W, readdata_W
  );

  modport slave (
    input  in_valid, regw_M, regmem_M, regScr_M, ALUrslt_M, readdata_M, out_ready,
    output in_ready, out_valid, regw_W, regmem_W, regScr_W, ALUrslt_W, readdata_W
  );

endinterface

// File: rtl/mw_skid_pipe_reg.sv
// Generic write-enabled register with synchronous active-high reset to zero.
//   clk, rst : clock, synchronous reset
//   wen_i    : load d_i on the next edge
//   d_i, q_o : data in / registered data out
module mw_skid_pipe_reg #(
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (wen_i) q_d = d_i;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mw_skid_pipe.sv
// Memory-writeback pipeline register with valid/ready handshake and a 2-entry skid buffer.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : squash all held entries (valid bits only; payload stays stale)
//   bus       : MEM-side input channel and WB-side output channel (slave modport)
//   stall_cnt : saturating count of cycles with out_valid=1 and out_ready=0
// in_ready is a flop, so out_ready never reaches in_ready combinationally.
module mw_skid_pipe
  import mw_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned M  = DefM,
  parameter int unsigned CW = DefCw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  mw_skid_pipe_if.slave bus,
  output logic [CW-1:0] stall_cnt
);

  typedef struct packed {
    logic         regw;
    logic         regmem;
    logic [M-1:0] reg_scr;
    logic [N-1:0] alu_rslt;
    logic [N-1:0] read_data;
  } bundle_t;

  typedef struct packed {
    logic    valid;
    bundle_t data;
  } slot_t;

  localparam int unsigned SlotW = bundle_width(N, M) + 1;

  mw_state_t     state_d, state_q;
  logic          in_ready_d, in_ready_q;
  logic [CW-1:0] stall_cnt_d, stall_cnt_q;

  slot_t   main_d, main_q, skid_d, skid_q;
  logic    main_wen, skid_wen;
  bundle_t in_bundle;
  logic    accept, consume;

  assign in_bundle = '{regw:      bus.regw_M,
                       regmem:    bus.regmem_M,
                       reg_scr:   bus.regScr_M,
                       alu_rslt:  bus.ALUrslt_M,
                       read_data: bus.readdata_M};

  assign accept  = bus.in_valid & in_ready_q;
  assign consume = main_q.valid & bus.out_ready;

  mw_skid_pipe_reg #(
    .Width (SlotW)
  ) u_main_slot (
    .clk   (clk),
    .rst   (rst),
    .wen_i (main_wen),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  mw_skid_pipe_reg #(
    .Width (SlotW)
  ) u_skid_slot (
    .clk   (clk),
    .rst   (rst),
    .wen_i (skid_wen),
    .d_i   (skid_d),
    .q_o   (skid_q)
  );

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    main_wen = 1'b0;
    skid_wen = 1'b0;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d   = '{valid: 1'b1, data: in_bundle};
          main_wen = 1'b1;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (accept && consume) begin
          main_d   = '{valid: 1'b1, data: in_bundle};
          main_wen = 1'b1;
        end else if (accept) begin
          skid_d   = '{valid: 1'b1, data: in_bundle};
          skid_wen = 1'b1;
          state_d  = StFull;
        end else if (consume) begin
          main_d.valid = 1'b0;
          main_wen     = 1'b1;
          state_d      = StEmpty;
        end
      end
      StFull: begin
        // in_ready is low here, so only the skid->main move can happen.
        if (consume) begin
          main_d       = skid_q;
          main_wen     = 1'b1;
          skid_d.valid = 1'b0;
          skid_wen     = 1'b1;
          state_d      = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Squash overrides any handshake; payload bits are rewritten with their own value.
    if (flush) begin
      main_d       = main_q;
      main_d.valid = 1'b0;
      skid_d       = skid_q;
      skid_d.valid = 1'b0;
      main_wen     = 1'b1;
      skid_wen     = 1'b1;
      state_d      = StEmpty;
    end
  end

  assign in_ready_d = (state_d != StFull);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_q.valid && !bus.out_ready && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = main_q.valid;
  assign bus.regw_W     = main_q.data.regw;
  assign bus.regmem_W   = main_q.data.regmem;
  assign bus.regScr_W   = main_q.data.reg_scr;
  assign bus.ALUrslt_W  = main_q.data.alu_rslt;
  assign bus.readdata_W = main_q.data.read_data;
  assign stall_cnt      = stall_cnt_q;

endmodule
